// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: arbitrates direction presses, queues accepted turns and gates
// game steps through an IDLE/RUN/PAUSE/OVER state machine.
module snake_dir_ctrl #(
    parameter int         QDEPTH   = 2,
    parameter logic [1:0] INIT_DIR = 2'd3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      press_up,
    input  logic                      press_down,
    input  logic                      press_left,
    input  logic                      press_right,
    input  logic                      press_pause,
    input  logic                      game_tick,
    input  logic                      game_over,
    output logic [1:0]                dir,
    output logic                      step_en,
    output logic [1:0]                state,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      key_drop
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    dir_q, dir_d;
    logic          step_en_q, step_en_d;
    logic          key_drop_q, key_drop_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    mem_q [QDEPTH];
    logic [1:0]    mem_d [QDEPTH];

    logic          cand_v, over_hit, active, pop, push, legal, room;
    logic [1:0]    cand, ref_dir;

    always_comb begin
        cand_v     = press_up | press_down | press_left | press_right;
        cand       = press_up ? 2'd0 : press_down ? 2'd1 : press_left ? 2'd2 : 2'd3;
        // New turns are judged against the last queued turn, not the live direction
        ref_dir    = (cnt_q != '0) ? mem_q[wr_ptr_q - PW'(1)] : dir_q;
        over_hit   = game_over && (state_q != S_OVER);
        active     = (state_q == S_IDLE) || (state_q == S_RUN);
        pop        = !over_hit && (state_q == S_RUN) && game_tick && (cnt_q != '0);
        room       = (cnt_q < CW'(QDEPTH)) || pop;
        legal      = (cand != ref_dir) && (cand != (ref_dir ^ 2'b01));
        push       = !over_hit && active && cand_v && legal && room;
        key_drop_d = !over_hit && active && cand_v && !(legal && room);
        step_en_d  = !over_hit && (state_q == S_RUN) && game_tick;
        mem_d      = mem_q;
        if (push)
            mem_d[wr_ptr_q] = cand;
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        dir_d      = pop ? mem_q[rd_ptr_q] : dir_q;
        state_d    = state_q;
        if (over_hit) begin
            state_d  = S_OVER;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                S_IDLE:  state_d = push ? S_RUN : S_IDLE;
                S_RUN:   state_d = press_pause ? S_PAUSE : S_RUN;
                S_PAUSE: state_d = press_pause ? S_RUN : S_PAUSE;
                default: begin
                    if (press_pause) begin
                        state_d  = S_IDLE;
                        dir_d    = INIT_DIR;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        cnt_d    = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dir_q      <= INIT_DIR;
            step_en_q  <= 1'b0;
            key_drop_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < QDEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            step_en_q  <= step_en_d;
            key_drop_q <= key_drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
        end
    end

    assign dir      = dir_q;
    assign step_en  = step_en_q;
    assign state    = state_q;
    assign q_count  = cnt_q;
    assign key_drop = key_drop_q;
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: scoreboard bench; each stimulus cycle queues the expected
// {dir, step_en, state, q_count, key_drop} that must appear after the edge.
module tb_snake_dir_ctrl;
    localparam logic [4:0] NO = 5'b00000;
    localparam logic [4:0] UP = 5'b10000;
    localparam logic [4:0] DN = 5'b01000;
    localparam logic [4:0] LT = 5'b00100;
    localparam logic [4:0] RT = 5'b00010;
    localparam logic [4:0] PS = 5'b00001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       press_up = 1'b0, press_down = 1'b0, press_left = 1'b0;
    logic       press_right = 1'b0, press_pause = 1'b0;
    logic       game_tick = 1'b0, game_over = 1'b0;
    logic [1:0] dir, state;
    logic       step_en, key_drop;
    logic [1:0] q_count;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] exp_q [$];
    string      tag_q [$];

    always #5 clk = ~clk;

    snake_dir_ctrl #(.QDEPTH(2), .INIT_DIR(2'd3)) dut (
        .clk(clk), .rst_n(rst_n),
        .press_up(press_up), .press_down(press_down), .press_left(press_left),
        .press_right(press_right), .press_pause(press_pause),
        .game_tick(game_tick), .game_over(game_over),
        .dir(dir), .step_en(step_en), .state(state),
        .q_count(q_count), .key_drop(key_drop)
    );

    function automatic logic [7:0] obs();
        return {dir, step_en, state, q_count, key_drop};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got dir/step/state/cnt/drop=%b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
                      tag, got[7:6], got[5], got[4:3], got[2:1], got[0],
                      want[7:6], want[5], want[4:3], want[2:1], want[0]);
    endtask

    task automatic cyc(input string tag, input logic [4:0] k, input logic tick, input logic go,
                       input logic [1:0] e_dir, input logic e_step, input logic [1:0] e_st,
                       input logic [1:0] e_cnt, input logic e_drop);
        {press_up, press_down, press_left, press_right, press_pause} = k;
        game_tick = tick;
        game_over = go;
        exp_q.push_back({e_dir, e_step, e_st, e_cnt, e_drop});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        {press_up, press_down, press_left, press_right, press_pause} = NO;
        game_tick = 1'b0;
        game_over = 1'b0;
        chk(tag_q.pop_front(), obs(), exp_q.pop_front());
    endtask

    initial begin
        #12;
        chk("reset", obs(), {2'd3, 1'b0, 2'd0, 2'd0, 1'b0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("idle_same_dir_drop", RT, 0, 0, 3, 0, 0, 0, 1);
        cyc("idle_up_starts",     UP, 0, 0, 3, 0, 1, 1, 0);
        cyc("first_step",         NO, 1, 0, 0, 1, 1, 0, 0);
        cyc("quiet",              NO, 0, 0, 0, 0, 1, 0, 0);
        cyc("push_right",         RT, 0, 0, 0, 0, 1, 1, 0);
        cyc("step_right",         NO, 1, 0, 3, 1, 1, 0, 0);
        cyc("push_up",            UP, 0, 0, 3, 0, 1, 1, 0);
        cyc("push_left_vs_tail",  LT, 0, 0, 3, 0, 1, 2, 0);
        cyc("full_drop",          DN, 0, 0, 3, 0, 1, 2, 1);
        cyc("pop_up",             NO, 1, 0, 0, 1, 1, 1, 0);
        cyc("pop_left",           NO, 1, 0, 2, 1, 1, 0, 0);
        cyc("refill_up",          UP, 0, 0, 2, 0, 1, 1, 0);
        cyc("refill_right",       RT, 0, 0, 2, 0, 1, 2, 0);
        cyc("full_push_pop",      DN, 1, 0, 0, 1, 1, 2, 0);
        cyc("pop_right",          NO, 1, 0, 3, 1, 1, 1, 0);
        cyc("pop_down",           NO, 1, 0, 1, 1, 1, 0, 0);
        cyc("push_right2",        RT, 0, 0, 1, 0, 1, 1, 0);
        cyc("step_right2",        NO, 1, 0, 3, 1, 1, 0, 0);
        cyc("multi_press_up_wins", UP | LT | RT, 0, 0, 3, 0, 1, 1, 0);
        cyc("step_up",            NO, 1, 0, 0, 1, 1, 0, 0);
        cyc("push_right3",        RT, 0, 0, 0, 0, 1, 1, 0);
        cyc("step_right3",        NO, 1, 0, 3, 1, 1, 0, 0);
        cyc("reverse_drop",       LT, 0, 0, 3, 0, 1, 0, 1);
        cyc("push_up2",           UP, 0, 0, 3, 0, 1, 1, 0);
        cyc("pause",              PS, 0, 0, 3, 0, 2, 1, 0);
        cyc("pause_tick",         NO, 1, 0, 3, 0, 2, 1, 0);
        cyc("pause_press",        LT, 0, 0, 3, 0, 2, 1, 0);
        cyc("resume",             PS, 0, 0, 3, 0, 1, 1, 0);
        cyc("resume_step",        NO, 1, 0, 0, 1, 1, 0, 0);
        cyc("push_right4",        RT, 0, 0, 0, 0, 1, 1, 0);
        cyc("over_beats_tick",    NO, 1, 1, 0, 0, 3, 0, 0);
        cyc("over_held",          UP, 1, 1, 0, 0, 3, 0, 0);
        cyc("restart",            PS, 0, 0, 3, 0, 0, 0, 0);
        cyc("idle_tick",          NO, 1, 0, 3, 0, 0, 0, 0);
        cyc("idle_pause",         PS, 0, 0, 3, 0, 0, 0, 0);
        cyc("over_from_idle",     UP, 0, 1, 3, 0, 3, 0, 0);
        cyc("restart_go_high",    PS, 0, 1, 3, 0, 0, 0, 0);
        cyc("reenter_over",       NO, 0, 1, 3, 0, 3, 0, 0);
        cyc("restart2",           PS, 0, 0, 3, 0, 0, 0, 0);
        cyc("start_up",           UP, 0, 0, 3, 0, 1, 1, 0);
        cyc("step_up2",           NO, 1, 0, 0, 1, 1, 0, 0);
        cyc("push_left",          LT, 0, 0, 0, 0, 1, 1, 0);
        cyc("push_down",          DN, 0, 0, 0, 0, 1, 2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", obs(), {2'd3, 1'b0, 2'd0, 2'd0, 1'b0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("post_reset_idle",    NO, 1, 0, 3, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
Direction and step scheduler for the snake game, driven by the four direction key debouncers and one pause/start key debouncer.
- Arbitrates simultaneous direction presses and rejects reversals.
- Buffers accepted turns in a small FIFO so fast double-taps are applied on consecutive steps.
- Gates the game step timer with a run/pause/over state machine.
- Sits between the key debouncers and the snake body/LED-array update logic.

Parameters:
QDEPTH, 2, turn FIFO depth; must be a power of 2, range 2..8.
INIT_DIR, 2'd3, direction loaded at reset and on restart. Encoding: 0=up, 1=down, 2=left, 3=right; opposite(d) = d ^ 2'b01.

Ports:
clk  input  1  system clock, 50MHz
rst_n  input  1  asynchronous active-low reset
press_up  input  1  one-cycle debounced press pulse
press_down  input  1  one-cycle debounced press pulse
press_left  input  1  one-cycle debounced press pulse
press_right  input  1  one-cycle debounced press pulse
press_pause  input  1  one-cycle pause/start/restart pulse
game_tick  input  1  one-cycle pulse from step timer
game_over  input  1  level, collision detected by body logic
dir  output  2  direction for the current step
step_en  output  1  one-cycle pulse: advance snake using dir
state  output  2  0=IDLE, 1=RUN, 2=PAUSE, 3=OVER
q_count  output  clog2(QDEPTH)+1  turns buffered
key_drop  output  1  one-cycle pulse: a direction press was rejected

Behaviour:
- Reset (async, rst_n=0):
  - dir=INIT_DIR, step_en=0, state=IDLE, q_count=0, key_drop=0.
  - FIFO pointers cleared.
- Press arbitration: if several direction pulses arrive in the same cycle, fixed priority up > down > left > right. Only the winner is considered; losers are ignored silently (no key_drop).
- Reference direction ref = FIFO tail entry if q_count>0, else dir.
- Acceptance, evaluated in IDLE or RUN only:
  - Candidate c is accepted if c != ref, c != opposite(ref), and q_count < QDEPTH.
  - Accepted: c is written at the tail, q_count increments next cycle.
  - Otherwise key_drop=1 for one cycle.
  - Presses in PAUSE or OVER are ignored with no key_drop.
- Step, RUN only, on game_tick:
  - Next cycle step_en=1.
  - If q_count>0, the FIFO head is popped and dir takes the head value in that same cycle. Otherwise dir holds.
  - Latency game_tick -> step_en/dir = 1 cycle.
  - game_tick in IDLE, PAUSE or OVER: no step_en.
- Simultaneous push and pop in the same cycle:
  - Both occur and q_count is unchanged.
  - Push is allowed when full if a pop occurs in that same cycle.
  - ref uses the pre-pop tail.
- FSM:
  - IDLE: an accepted direction press -> RUN; the press is also enqueued. press_pause is ignored.
  - RUN: press_pause -> PAUSE.
  - PAUSE: press_pause -> RUN. The FIFO is retained.
  - OVER: press_pause -> IDLE; dir reloads INIT_DIR and the FIFO is flushed.
  - game_over=1 in any state except OVER -> OVER next cycle, FIFO flushed. It has priority over the press, tick and pause actions of that cycle: no step_en is issued.
  - game_over held high in OVER has no effect. press_pause in OVER is accepted even if game_over is still high; game_over then re-enters OVER next cycle.
- Pointer arithmetic: wraps modulo QDEPTH; q_count never exceeds QDEPTH or underflows.
- step_en and key_drop are single-cycle pulses, never held.

Test Plan:
- Reset, then press_right in IDLE (INIT_DIR=3) -> key_drop=1, state stays IDLE. Then press_up -> state=RUN, q_count=1. Next game_tick -> 1 cycle later step_en=1, dir=0, q_count=0.
- RUN with dir=3: press_up then press_left before the tick -> q_count=2. Two ticks -> dir=0 on the first step_en, dir=2 on the second. A third press while full (QDEPTH=2) -> key_drop=1.
- press_up, press_left and press_right in the same cycle with dir=3 -> only up is enqueued, key_drop=0. press_left alone with dir=3 and q_count=0 -> key_drop=1.
- RUN, then press_pause -> state=2; game_tick and direction presses produce no step_en, q_count unchanged. press_pause -> state=1, the next tick steps normally.
- game_over pulse in the same cycle as game_tick with q_count=1 -> state=3, no step_en, q_count=0. press_pause -> state=0, dir=3.
- Assert rst_n=0 mid-RUN with q_count=2 -> all outputs return to their reset values immediately, without waiting for a clock edge.
